// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART receiver.
// Pure declarations: no latency, no flow control.
package uart_pkg;

  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUD         = 19200;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = 12;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to idle-high.
// Latency 2 clk, no backpressure.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/mod_uart_rx.sv
// UART 8N1 receiver: flag_done pulses ~9.5 bit times after the start edge (+2-3 clk sync).
// No backpressure: the consumer must take rx_reg when flag_done pulses.
module mod_uart_rx #(
  parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int BAUD     = uart_pkg::BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       flag_done,
  output logic [7:0] rx_reg
);

  import uart_pkg::*;

  localparam int                 BIT_CLKS = CLK_FREQ / BAUD;
  localparam logic [CNT_W-1:0]   BIT_END  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0]   HALF_END = CNT_W'(BIT_CLKS / 2 - 1);

  logic             rx_s;
  rx_state_t        state;
  rx_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  logic             half_end;
  logic             bit_end;
  logic             cnt_run;
  logic             idx_clr;
  logic             sample;
  logic             load;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (rx),
    .dout  (rx_s)
  );

  assign half_end = (cnt == HALF_END);
  assign bit_end  = (cnt == BIT_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_end) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter runs until the end of the current interval and self-clears on it.
  always_comb begin
    cnt_run = 1'b0;
    idx_clr = 1'b0;
    sample  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE:  idx_clr = !rx_s;
      START: begin
        cnt_run = !half_end;
        idx_clr = half_end;
      end
      DATA: begin
        cnt_run = !bit_end;
        sample  = bit_end;
      end
      STOP: begin
        cnt_run = !bit_end;
        load    = bit_end && rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_reg    <= 8'h00;
      flag_done <= 1'b0;
    end else begin
      cnt       <= cnt_run ? cnt + CNT_W'(1) : '0;
      flag_done <= load;
      if (idx_clr)     bit_idx <= '0;
      else if (sample) bit_idx <= bit_idx + 3'd1;
      if (sample)      shift[bit_idx] <= rx_s;
      if (load)        rx_reg <= shift;
    end
  end

endmodule

// File: tb/tb_mod_uart_rx.sv
// Self-checking bench for mod_uart_rx at a scaled baud rate (25 clk per bit).
// Reference: bytes with a high stop bit are expected, in order, as one-cycle pulses.
module tb_mod_uart_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 2_000_000;
  localparam int B        = CLK_FREQ / BAUD;
  localparam int LAT_MIN  = (19 * B) / 2 + 2 - 3;
  localparam int LAT_MAX  = (19 * B) / 2 + 3 + 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic       flag_done;
  logic [7:0] rx_reg;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;

  logic [7:0] pulse_q[$];
  int         pulse_cyc_q[$];
  int         long_pulse   = 0;
  int         stray_change = 0;
  logic       prev_flag    = 1'b0;
  logic       prev_reset   = 1'b0;
  logic [7:0] prev_reg     = 8'h00;
  logic [7:0] model_reg    = 8'h00;

  mod_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .flag_done (flag_done),
    .rx_reg    (rx_reg)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (flag_done) begin
      if (prev_flag) long_pulse++;
      else begin
        pulse_q.push_back(rx_reg);
        pulse_cyc_q.push_back(cyc);
      end
    end
    if (reset && prev_reset && !flag_done && rx_reg !== prev_reg) stray_change++;
    prev_flag  = flag_done;
    prev_reset = reset;
    prev_reg   = rx_reg;
  end

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int start_cyc);
    start_cyc = cyc;
    hold(1'b0, B);
    for (int i = 0; i < 8; i++) hold(d[i], B);
    hold(stop, B);
    rx = 1'b1;
  endtask

  task automatic clear_obs();
    pulse_q.delete();
    pulse_cyc_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (rx_reg !== 8'h00) begin
      n_err++; $display("FAIL reset_rx_reg: got %h, need 00", rx_reg);
    end
    n_vec++;
    if (flag_done !== 1'b0) begin
      n_err++; $display("FAIL reset_flag: got %b, need 0", flag_done);
    end
    clear_obs();
    reset = 1'b1;
    hold(1'b1, B);
    n_vec++;
    if (pulse_q.size() != 0 || rx_reg !== 8'h00) begin
      n_err++; $display("FAIL reset_idle: pulses %0d rx_reg %h, need 0 pulses rx_reg 00", pulse_q.size(), rx_reg);
    end
  endtask

  task automatic test_single_frame();
    int sc;
    int lat;
    clear_obs();
    send_frame(8'hD1, 1'b1, sc);
    hold(1'b1, 3 * B);
    model_reg = 8'hD1;
    n_vec++;
    if (pulse_q.size() != 1) begin
      n_err++; $display("FAIL single_count: got %0d pulses, need 1", pulse_q.size());
    end else begin
      n_vec++;
      if (pulse_q[0] !== 8'hD1) begin
        n_err++; $display("FAIL single_data: got %h, need d1", pulse_q[0]);
      end
      lat = pulse_cyc_q[0] - sc;
      n_vec++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
        n_err++; $display("FAIL single_latency: got %0d clk, need %0d..%0d", lat, LAT_MIN, LAT_MAX);
      end
    end
    n_vec++;
    if (rx_reg !== model_reg) begin
      n_err++; $display("FAIL single_hold: got %h, need %h", rx_reg, model_reg);
    end
  endtask

  task automatic test_reset_pulse();
    int sc;
    clear_obs();
    reset = 1'b0;
    hold(1'b1, B);
    model_reg = 8'h00;
    n_vec++;
    if (rx_reg !== 8'h00) begin
      n_err++; $display("FAIL rstpulse_clear: got %h, need 00", rx_reg);
    end
    reset = 1'b1;
    hold(1'b1, B);
    send_frame(8'h2C, 1'b1, sc);
    hold(1'b1, 3 * B);
    model_reg = 8'h2C;
    n_vec++;
    if (pulse_q.size() != 1 || rx_reg !== model_reg) begin
      n_err++; $display("FAIL rstpulse_frame: pulses %0d rx_reg %h, need 1 pulse rx_reg %h", pulse_q.size(), rx_reg, model_reg);
    end
  endtask

  task automatic test_glitch();
    int sc;
    clear_obs();
    for (int g = 0; g < 6; g++) begin
      hold(1'b0, $urandom_range(1, B / 2 - 4));
      hold(1'b1, 2 * B);
    end
    n_vec++;
    if (pulse_q.size() != 0 || rx_reg !== model_reg) begin
      n_err++; $display("FAIL glitch_ignored: pulses %0d rx_reg %h, need 0 pulses rx_reg %h", pulse_q.size(), rx_reg, model_reg);
    end
    send_frame(8'h96, 1'b1, sc);
    hold(1'b1, 3 * B);
    model_reg = 8'h96;
    n_vec++;
    if (pulse_q.size() != 1 || rx_reg !== model_reg) begin
      n_err++; $display("FAIL glitch_rearm: pulses %0d rx_reg %h, need 1 pulse rx_reg %h", pulse_q.size(), rx_reg, model_reg);
    end
  endtask

  task automatic test_framing_error();
    int sc;
    clear_obs();
    send_frame(8'h55, 1'b0, sc);
    hold(1'b1, 3 * B);
    n_vec++;
    if (pulse_q.size() != 0 || rx_reg !== model_reg) begin
      n_err++; $display("FAIL framing_drop: pulses %0d rx_reg %h, need 0 pulses rx_reg %h", pulse_q.size(), rx_reg, model_reg);
    end
    send_frame(8'hA5, 1'b1, sc);
    hold(1'b1, 3 * B);
    model_reg = 8'hA5;
    n_vec++;
    if (pulse_q.size() != 1 || rx_reg !== model_reg) begin
      n_err++; $display("FAIL framing_recover: pulses %0d rx_reg %h, need 1 pulse rx_reg %h", pulse_q.size(), rx_reg, model_reg);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int sc;
    d = 8'hF7;
    clear_obs();
    hold(1'b0, B);
    for (int i = 0; i < 3; i++) hold(d[i], B);
    hold(d[3], B / 2);
    reset = 1'b0;
    hold(d[3], B - B / 2);
    hold(d[4], B);
    n_vec++;
    if (rx_reg !== 8'h00 || flag_done !== 1'b0) begin
      n_err++; $display("FAIL midrst_clear: rx_reg %h flag %b, need 00 0", rx_reg, flag_done);
    end
    hold(d[5], B / 2);
    reset = 1'b1;
    hold(d[5], B - B / 2);
    hold(d[6], B);
    hold(d[7], B);
    hold(1'b1, 4 * B);
    model_reg = 8'h00;
    n_vec++;
    if (pulse_q.size() != 0 || rx_reg !== model_reg) begin
      n_err++; $display("FAIL midrst_abort: pulses %0d rx_reg %h, need 0 pulses rx_reg 00", pulse_q.size(), rx_reg);
    end
    send_frame(8'h3C, 1'b1, sc);
    hold(1'b1, 3 * B);
    model_reg = 8'h3C;
    n_vec++;
    if (pulse_q.size() != 1 || rx_reg !== model_reg) begin
      n_err++; $display("FAIL midrst_next: pulses %0d rx_reg %h, need 1 pulse rx_reg %h", pulse_q.size(), rx_reg, model_reg);
    end
  endtask

  task automatic test_random(input int nframes, input bit gaps);
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic       stop;
    int         sc;
    clear_obs();
    for (int i = 0; i < nframes; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, sc);
      if (gaps || !stop) hold(1'b1, $urandom_range(2, 5) * B);
      if (stop) begin
        exp_q.push_back(d);
        model_reg = d;
      end
    end
    hold(1'b1, 3 * B);
    n_vec++;
    if (pulse_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL random_count: got %0d pulses, need %0d", pulse_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (pulse_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL random_byte[%0d]: got %h, need %h", i, pulse_q[i], exp_q[i]);
        end
      end
    end
    n_vec++;
    if (rx_reg !== model_reg) begin
      n_err++; $display("FAIL random_final: got %h, need %h", rx_reg, model_reg);
    end
  endtask

  task automatic test_pulse_shape();
    n_vec++;
    if (long_pulse != 0) begin
      n_err++; $display("FAIL pulse_width: got %0d extra high cycles, need 0", long_pulse);
    end
    n_vec++;
    if (stray_change != 0) begin
      n_err++; $display("FAIL reg_stable: got %0d changes without flag_done, need 0", stray_change);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_reset_pulse();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_random(30, 1'b1);
    test_random(8, 1'b0);
    test_pulse_shape();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
